// File: rtl/ct_spsram_ctrl_pkg.sv
// rtl/ct_spsram_ctrl_pkg.sv - shared constants and state type for the SRAM front-end controller
package ct_spsram_ctrl_pkg;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 22;
  localparam int INIT_COUNT     = 512;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/ct_spsram_512x22_ctrl.sv
// rtl/ct_spsram_512x22_ctrl.sv - request/response front end for a 512x22 single-port SRAM
// Zero-fills the array after reset or flush, then serves masked writes and one read at a time.
module ct_spsram_512x22_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  flush,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam int CW = $clog2(INIT_COUNT) + 1;

  ctrl_state_t   state;
  logic [CW-1:0] cnt;
  logic          rd_s1;
  logic          rd_s2;
  logic          rd_busy;
  logic          flush_go;
  logic          accept;

  // A read stays "in the pipeline" from accept until its response is taken.
  assign rd_busy  = rd_s1 | rd_s2 | rsp_vld;
  assign flush_go = (state == ST_RUN) & flush & ~rd_busy;

  always_comb begin
    req_rdy = 1'b0;
    if (state == ST_RUN && !flush_go) begin
      if (req_wr) req_rdy = 1'b1;
      else        req_rdy = ~rd_s1 & ~rd_s2 & (~rsp_vld | rsp_rdy);
    end
  end

  assign accept = req_vld & req_rdy;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
      rd_s1     <= 1'b0;
      rd_s2     <= 1'b0;
      rsp_vld   <= 1'b0;
      rsp_data  <= '0;
      CEN       <= 1'b1;
      GWEN      <= 1'b1;
      WEN       <= '1;
      A         <= '0;
      D         <= '0;
    end else begin
      CEN   <= 1'b1;
      GWEN  <= 1'b1;
      WEN   <= '1;
      rd_s1 <= 1'b0;
      rd_s2 <= rd_s1;

      // Q is valid the cycle after the read strobe; capture it then.
      if (rd_s2) begin
        rsp_data <= Q;
        rsp_vld  <= 1'b1;
      end else if (rsp_vld && rsp_rdy) begin
        rsp_vld  <= 1'b0;
      end

      case (state)
        ST_INIT: begin
          if (cnt == CW'(INIT_COUNT)) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end else begin
            CEN  <= 1'b0;
            GWEN <= 1'b0;
            WEN  <= '0;
            A    <= ADDR_WIDTH'(cnt);
            D    <= '0;
            cnt  <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (flush_go) begin
            state     <= ST_INIT;
            cnt       <= '0;
            init_done <= 1'b0;
          end else if (accept) begin
            CEN <= 1'b0;
            A   <= req_addr;
            if (req_wr) begin
              GWEN <= 1'b0;
              WEN  <= ~req_wmask;
              D    <= req_wdata;
            end else begin
              rd_s1 <= 1'b1;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ct_spsram_512x22_ctrl.sv
// tb/tb_ct_spsram_512x22_ctrl.sv - self-checking bench for ct_spsram_512x22_ctrl with a behavioural SRAM
module tb_ct_spsram_512x22_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic        req_wr = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [21:0] req_wdata = '0;
  logic [21:0] req_wmask = '0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b1;
  logic [21:0] rsp_data;
  logic        flush = 1'b0;
  logic        init_done;
  logic [8:0]  A;
  logic        CEN;
  logic        GWEN;
  logic [21:0] WEN;
  logic [21:0] D;
  logic [21:0] Q;

  ct_spsram_512x22_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .flush(flush), .init_done(init_done),
    .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port SRAM: bit-masked write, registered read data.
  logic [21:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = 22'($urandom);
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      else       Q <= mem[A];
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [21:0] data;
    int          acc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [21:0] wdata;
    logic [21:0] wmask;
    logic [21:0] exp_wen;
    logic [21:0] exp_rdata;
  } vec_t;
  vec_t vecs[11];

  logic        prev_vld = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [21:0] prev_data = '0;

  // Response monitor: latency, hold stability and data against the scoreboard.
  always @(negedge CLK) begin
    #2;
    if (!RST && rsp_vld) begin
      if (sb.size() == 0) chk("spurious_rsp", 32'(rsp_vld), 32'd0);
      else begin
        if (!prev_vld) chk("rsp_latency", 32'(cyc - sb[0].acc), 32'd3);
        if (prev_vld && !prev_rdy) chk("rsp_stable", 32'(rsp_data), 32'(prev_data));
        if (rsp_rdy) begin
          chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
          void'(sb.pop_front());
        end
      end
    end
    prev_vld  = rsp_vld;
    prev_rdy  = rsp_rdy;
    prev_data = rsp_data;
  end

  task automatic do_req(input logic wr, input logic [8:0] addr, input logic [21:0] wdata,
                        input logic [21:0] wmask, input logic [21:0] exp_wen,
                        input logic [21:0] exp_rdata);
    int n = 0;
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    #1;
    while (!req_rdy && n < 40) begin
      @(negedge CLK); #1; n++;
    end
    if (!req_rdy) begin
      chk("req_timeout", 32'(req_rdy), 32'd1);
      req_vld = 1'b0;
      return;
    end
    if (!wr) sb.push_back('{exp_rdata, cyc});
    @(posedge CLK); #1;
    req_vld = 1'b0;
    @(negedge CLK); #1;
    chk("pin_cen", 32'(CEN), 32'd0);
    chk("pin_a", 32'(A), 32'(addr));
    if (wr) begin
      chk("pin_gwen_wr", 32'(GWEN), 32'd0);
      chk("pin_wen_wr", 32'(WEN), 32'(exp_wen));
      chk("pin_d", 32'(D), 32'(wdata));
    end else begin
      chk("pin_gwen_rd", 32'(GWEN), 32'd1);
      chk("pin_wen_rd", 32'(WEN), 32'h3FFFFF);
    end
  endtask

  // Expects the zero-fill to start on the next cycle and run exactly 512 writes.
  task automatic init_check();
    int n = 0;
    int bad = 0;
    @(negedge CLK); #1;
    while (CEN !== 1'b0 && n < 10) begin
      @(negedge CLK); #1; n++;
    end
    chk("init_start", 32'(n), 32'd0);
    for (int i = 0; i < 512; i++) begin
      if (CEN !== 1'b0 || GWEN !== 1'b0 || WEN !== 22'h0 || D !== 22'h0 ||
          A !== 9'(i) || req_rdy !== 1'b0 || init_done !== 1'b0) bad++;
      @(negedge CLK);
      req_wr = ~req_wr;
      #1;
    end
    chk("init_seq_bad_steps", 32'(bad), 32'd0);
    chk("init_done_513", 32'(init_done), 32'd1);
    chk("init_cen_idle", 32'(CEN), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_vld) && n < 50) begin
      @(negedge CLK); #1; n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0]  = '{1'b1, 9'h005, 22'h2AAAAA, 22'h3FFFFF, 22'h000000, 22'h000000};
    vecs[1]  = '{1'b0, 9'h005, 22'h000000, 22'h000000, 22'h3FFFFF, 22'h2AAAAA};
    vecs[2]  = '{1'b1, 9'h1FF, 22'h3FFFFF, 22'h0007FF, 22'h3FF800, 22'h000000};
    vecs[3]  = '{1'b0, 9'h1FF, 22'h000000, 22'h000000, 22'h3FFFFF, 22'h0007FF};
    vecs[4]  = '{1'b1, 9'h000, 22'h155555, 22'h3FFFFF, 22'h000000, 22'h000000};
    vecs[5]  = '{1'b1, 9'h000, 22'h3FFFFF, 22'h00F0F0, 22'h3F0F0F, 22'h000000};
    vecs[6]  = '{1'b0, 9'h000, 22'h000000, 22'h000000, 22'h3FFFFF, 22'h15F5F5};
    vecs[7]  = '{1'b1, 9'h010, 22'h123456, 22'h000000, 22'h3FFFFF, 22'h000000};
    vecs[8]  = '{1'b0, 9'h010, 22'h000000, 22'h000000, 22'h3FFFFF, 22'h000000};
    vecs[9]  = '{1'b1, 9'h0AA, 22'h0ABCDE, 22'h3FFFFF, 22'h000000, 22'h000000};
    vecs[10] = '{1'b0, 9'h0AA, 22'h000000, 22'h000000, 22'h3FFFFF, 22'h0ABCDE};

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    chk("rst_cen", 32'(CEN), 32'd1);
    chk("rst_gwen", 32'(GWEN), 32'd1);
    chk("rst_wen", 32'(WEN), 32'h3FFFFF);
    chk("rst_a", 32'(A), 32'd0);
    chk("rst_d", 32'(D), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    RST = 1'b0;
    init_check();

    // Table vectors; each read directly follows its write
    for (int i = 0; i < 11; i++)
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
             vecs[i].exp_wen, vecs[i].exp_rdata);
    wait_drain();

    // Response back-pressure with a write slipping past the pending read
    rsp_rdy = 1'b0;
    do_req(1'b0, 9'h005, '0, '0, 22'h3FFFFF, 22'h2AAAAA);
    n = 0;
    while (!rsp_vld && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    chk("bp_rsp_vld", 32'(rsp_vld), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      req_vld = 1'b0; req_wr = 1'b0; #1;
      chk("bp_rd_rdy", 32'(req_rdy), 32'd0);
      req_wr = 1'b1; #1;
      chk("bp_wr_rdy", 32'(req_rdy), 32'd1);
    end
    do_req(1'b1, 9'h020, 22'h0F0F0F, 22'h3FFFFF, 22'h000000, 22'h0);
    @(negedge CLK); #1;
    req_wr = 1'b0; rsp_rdy = 1'b1; #1;
    chk("bp_rd_rdy_release", 32'(req_rdy), 32'd1);
    @(negedge CLK);
    do_req(1'b0, 9'h020, '0, '0, 22'h3FFFFF, 22'h0F0F0F);
    wait_drain();

    // Flush wins over a same-cycle write, then the array reads back zero
    @(negedge CLK);
    flush = 1'b1; req_vld = 1'b1; req_wr = 1'b1; req_addr = 9'h005;
    req_wdata = 22'h111111; req_wmask = 22'h3FFFFF; #1;
    chk("flush_prio_rdy", 32'(req_rdy), 32'd0);
    @(posedge CLK); #1;
    flush = 1'b0; req_vld = 1'b0;
    @(negedge CLK); #1;
    chk("flush_init_done", 32'(init_done), 32'd0);
    chk("flush_no_write", 32'(CEN), 32'd1);
    init_check();
    do_req(1'b0, 9'h005, '0, '0, 22'h3FFFFF, 22'h000000);
    do_req(1'b0, 9'h1FF, '0, '0, 22'h3FFFFF, 22'h000000);
    wait_drain();

    // Reset pulse at init counter 200
    @(negedge CLK);
    RST = 1'b1; #1;
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
    @(negedge CLK); #1;
    while (!(A == 9'd200 && CEN == 1'b0) && n < 300) begin
      @(negedge CLK); #1; n++;
    end
    chk("reach_a200", 32'(A), 32'd200);
    RST = 1'b1; #1;
    chk("mid_rst_cen", 32'(CEN), 32'd1);
    chk("mid_rst_gwen", 32'(GWEN), 32'd1);
    chk("mid_rst_wen", 32'(WEN), 32'h3FFFFF);
    chk("mid_rst_a", 32'(A), 32'd0);
    chk("mid_rst_d", 32'(D), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    init_check();

    // Reset during a read drops the response
    do_req(1'b0, 9'h0AA, '0, '0, 22'h3FFFFF, 22'h000000);
    RST = 1'b1;
    sb.delete();
    #1;
    chk("rd_rst_rsp_vld", 32'(rsp_vld), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    init_check();
    chk("rd_rst_no_rsp", 32'(rsp_vld), 32'd0);
    do_req(1'b0, 9'h0AA, '0, '0, 22'h3FFFFF, 22'h000000);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ct_spsram_512x22_ctrl.md
CT_SPSRAM_512X22_CTRL -- requirements
Module: ct_spsram_512x22_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, SRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 22, SRAM data and bit-mask width.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_vld, input, 1, request valid.
REQ-006 SHALL have port req_rdy, output, 1, request ready.
REQ-007 SHALL have port req_wr, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, ADDR_WIDTH, entry index.
REQ-009 SHALL have port req_wdata, input, DATA_WIDTH, write data.
REQ-010 SHALL have port req_wmask, input, DATA_WIDTH, per-bit write enable; 1 = write the bit.
REQ-011 SHALL have port rsp_vld, output, 1, read data valid.
REQ-012 SHALL have port rsp_rdy, input, 1, read data accepted.
REQ-013 SHALL have port rsp_data, output, DATA_WIDTH, read data.
REQ-014 SHALL have port flush, input, 1, request to re-initialise the whole array to zero.
REQ-015 SHALL have port init_done, output, 1, high only in state RUN.
REQ-016 SHALL have SRAM-side ports A (ADDR_WIDTH), CEN (1), GWEN (1), WEN (DATA_WIDTH) and D (DATA_WIDTH) as outputs, and Q (DATA_WIDTH) as input, all driving or sampling a ct_spsram_512x22 instance.

Function
REQ-017 SHALL implement states INIT and RUN.
REQ-018 SHALL, in INIT, issue one write per cycle: A = init counter, D = 0, GWEN = 0, WEN = all 0; the counter runs 0 to 511, then the block enters RUN; req_rdy = 0 throughout.
REQ-019 SHALL, in RUN, enter INIT with counter = 0 when flush = 1 and no read is in the pipeline; flush SHALL take priority over a same-cycle request, which is not accepted.
REQ-020 SHALL handshake on req_vld & req_rdy.
REQ-021 SHALL drive req_rdy for a write as (state == RUN).
REQ-022 SHALL drive req_rdy for a read as RUN & no read in either pipe stage & (!rsp_vld | rsp_rdy); req_rdy SHALL depend on req_wr but never on req_vld.
REQ-023 SHALL register all SRAM-side outputs; a request accepted in cycle t drives the SRAM pins in cycle t+1.
REQ-024 SHALL drive a write as CEN = 0, GWEN = 0, WEN = ~req_wmask, D = req_wdata.
REQ-025 SHALL drive a read as CEN = 0, GWEN = 1, WEN = all 1.
REQ-026 SHALL drive idle as CEN = 1, GWEN = 1, WEN = all 1, with A and D holding their previous values.
REQ-027 SHALL sample Q in cycle t+2 into the rsp_data register; rsp_vld SHALL be high from cycle t+3 until the cycle where rsp_vld & rsp_rdy, and rsp_data SHALL be stable while rsp_vld & !rsp_rdy.
REQ-028 SHALL return a read issued one cycle after a write to the same address with the written data.
REQ-029 SHALL allow at most one read in flight or pending.
REQ-030 SHALL let writes proceed while a read is in flight or pending.

Reset
REQ-031 SHALL, while RST = 1, set state = INIT, counter = 0, rsp_vld = 0, rsp_data = 0, CEN = 1, GWEN = 1, WEN = all 1, A = 0, D = 0, init_done = 0 and req_rdy = 0.
REQ-032 SHALL, on RST asserted mid-INIT or mid-read, abort the operation with no response, then run a full 512-entry init after deassertion.

Structure
REQ-033 SHALL put ADDR_WIDTH and DATA_WIDTH defaults, the INIT/RUN state enum and the init-count constant 512 in shared package ct_spsram_ctrl_pkg.
REQ-034 SHALL contain no sub-module; the SRAM is instantiated by the parent beside this block.

Verification
REQ-035 SHALL cover: reset release -> CEN = 0 for exactly 512 cycles with A = 0..511, D = 0; init_done rises in cycle 513; req_rdy = 0 before that.
REQ-036 SHALL cover: write addr 0x05, data 0x2AAAAA, mask 0x3FFFFF, then read 0x05 with rsp_rdy = 1 -> rsp_vld 3 cycles after read accept, rsp_data = 0x2AAAAA.
REQ-037 SHALL cover: write addr 0x1FF, data 0x3FFFFF, mask 0x0007FF after init -> WEN = 0x3FF800; a following read returns 0x0007FF.
REQ-038 SHALL cover: read with rsp_rdy held 0 for 10 cycles -> rsp_data stable, read req_rdy = 0, write req_rdy = 1; rsp_rdy = 1 -> read req_rdy = 1 in the same cycle.
REQ-039 SHALL cover: flush in RUN with no read pending -> init_done = 0 next cycle, 512 zero writes, then a read of a previously written address returns 0.
REQ-040 SHALL cover: RST pulsed at init counter 200 -> SRAM pins return to the idle values, and init restarts at A = 0.
